// File: rtl/mbc_pkg.sv
// Shared types and bounds for the mux_bus_ctrl external-bus sequencer.
package mbc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LATCH,
    ST_ACCESS,
    ST_RECOVER
  } mbc_state_e;

  localparam int MBC_ADDR_BYTES_MIN = 2;
  localparam int MBC_ADDR_BYTES_MAX = 4;
  localparam int MBC_IDX_W          = 2;

endpackage

// File: rtl/mbc_le_shaper.sv
// Turns posedge-registered latch strobes into half-cycle pulses that fall at the
// following negedge, using a negedge-registered clear mask (clk is never gated).
module mbc_le_shaper #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] strobe,
  output logic [N-1:0] le
);

  logic [N-1:0] clr_q;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) clr_q <= '0;
    else        clr_q <= strobe;
  end

  // A bit is never strobed in two consecutive cycles, so the stale mask never hides a new pulse.
  assign le = strobe & ~clr_q;

endmodule

// File: rtl/mux_bus_ctrl.sv
// Multiplexed address/data bus sequencer: address-latch phases, access with wait states, recovery.
// Optional MBC_HICACHE_EN skips re-latching upper address bytes that match the last latched ones.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | req_ready high, waiting for a request
// ST_LATCH   | drive one address byte per cycle, pulse its le bit (high byte first)
// ST_ACCESS  | oe_n (read) or we_n (write) low for 1 + wait_cycles cycles
// ST_RECOVER | all strobes released, rsp_valid pulses
module mux_bus_ctrl
  import mbc_pkg::*;
#(
  parameter int ADDR_BYTES = 2,
  parameter int WAIT_W     = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [8*ADDR_BYTES-1:0] req_addr,
  input  logic [7:0]              req_wdata,
  input  logic [WAIT_W-1:0]       wait_cycles,
  output logic                    rsp_valid,
  output logic [7:0]              rsp_rdata,
  output logic [7:0]              bus_out,
  output logic                    bus_oe,
  input  logic [7:0]              bus_in,
  output logic [ADDR_BYTES-1:0]   le,
  output logic                    oe_n,
  output logic                    we_n
);

  if (ADDR_BYTES < MBC_ADDR_BYTES_MIN || ADDR_BYTES > MBC_ADDR_BYTES_MAX) begin : g_bad_cfg
    $error("mux_bus_ctrl: ADDR_BYTES out of range");
  end

  mbc_state_e                  state_q, state_d;
  logic [MBC_IDX_W-1:0]        idx_q, idx_d;
  logic [WAIT_W-1:0]           cnt_q, cnt_d;
  logic [8*ADDR_BYTES-1:0]     addr_q, addr_d;
  logic                        we_q, we_d;
  logic [7:0]                  wdata_q, wdata_d;
  logic                        ready_d, rsp_valid_d, bus_oe_d, oe_n_d, we_n_d;
  logic [7:0]                  rdata_d, bus_out_d;
  logic [ADDR_BYTES-1:0]       strobe_q, strobe_d;
  logic                        accept, hit;

  function automatic logic [7:0] addr_byte(input logic [8*ADDR_BYTES-1:0] a,
                                           input logic [MBC_IDX_W-1:0] i);
    addr_byte = '0;
    for (int k = 0; k < ADDR_BYTES; k++)
      if (i == MBC_IDX_W'(k)) addr_byte = a[8*k +: 8];
  endfunction

  function automatic logic [ADDR_BYTES-1:0] onehot(input logic [MBC_IDX_W-1:0] i);
    onehot = '0;
    for (int k = 0; k < ADDR_BYTES; k++)
      onehot[k] = (i == MBC_IDX_W'(k));
  endfunction

  assign accept = req_valid && req_ready && (state_q == ST_IDLE);

`ifdef MBC_HICACHE_EN
  logic [8*ADDR_BYTES-9:0] hi_q;
  logic                    hi_vld_q;

  assign hit = hi_vld_q && (req_addr[8*ADDR_BYTES-1:8] == hi_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q     <= '0;
      hi_vld_q <= 1'b0;
    end else if (accept && !hit) begin
      hi_q     <= req_addr[8*ADDR_BYTES-1:8];
      hi_vld_q <= 1'b1;
    end
  end
`else
  assign hit = 1'b0;
`endif

  // Outputs are computed one cycle ahead and registered, so they reset asynchronously.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    ready_d     = 1'b0;
    rsp_valid_d = 1'b0;
    rdata_d     = rsp_rdata;
    bus_out_d   = 8'h00;
    bus_oe_d    = 1'b0;
    strobe_d    = '0;
    oe_n_d      = 1'b1;
    we_n_d      = 1'b1;
    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (accept) begin
          addr_d    = req_addr;
          we_d      = req_we;
          wdata_d   = req_wdata;
          cnt_d     = wait_cycles;
          idx_d     = hit ? '0 : MBC_IDX_W'(ADDR_BYTES - 1);
          strobe_d  = onehot(idx_d);
          bus_out_d = addr_byte(req_addr, idx_d);
          bus_oe_d  = 1'b1;
          ready_d   = 1'b0;
          state_d   = ST_LATCH;
        end
      end
      ST_LATCH: begin
        if (idx_q == '0) begin
          state_d   = ST_ACCESS;
          oe_n_d    = we_q;
          we_n_d    = !we_q;
          bus_oe_d  = we_q;
          bus_out_d = we_q ? wdata_q : 8'h00;
        end else begin
          idx_d     = idx_q - 1'b1;
          strobe_d  = onehot(idx_d);
          bus_out_d = addr_byte(addr_q, idx_d);
          bus_oe_d  = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          state_d     = ST_RECOVER;
          rsp_valid_d = 1'b1;
          if (!we_q) rdata_d = bus_in;
        end else begin
          cnt_d     = cnt_q - 1'b1;
          oe_n_d    = we_q;
          we_n_d    = !we_q;
          bus_oe_d  = we_q;
          bus_out_d = we_q ? wdata_q : 8'h00;
        end
      end
      ST_RECOVER: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= 8'h00;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      bus_out   <= 8'h00;
      bus_oe    <= 1'b0;
      strobe_q  <= '0;
      oe_n      <= 1'b1;
      we_n      <= 1'b1;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      req_ready <= ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rdata_d;
      bus_out   <= bus_out_d;
      bus_oe    <= bus_oe_d;
      strobe_q  <= strobe_d;
      oe_n      <= oe_n_d;
      we_n      <= we_n_d;
    end
  end

  mbc_le_shaper #(.N(ADDR_BYTES)) u_le_shaper (
    .clk    (clk),
    .rst_n  (rst_n),
    .strobe (strobe_q),
    .le     (le)
  );

endmodule

// File: tb/tb_mux_bus_ctrl.sv
// Directed bench for mux_bus_ctrl: 2-byte and 3-byte instances, reads, writes, wait states,
// upper-byte cache behaviour (MBC_HICACHE_EN) and reset during an access.
module tb_mux_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic [2:0]  wait_cycles = '0;
  logic [7:0]  bus_in = '0;

  logic       rdy2, rv2, boe2, oen2, wen2;
  logic [7:0] rd2, bo2;
  logic [1:0] le2;
  logic       rdy3, rv3, boe3, oen3, wen3;
  logic [7:0] rd3, bo3;
  logic [2:0] le3;

  logic       m_ready, m_rv, m_boe, m_oen, m_wen;
  logic [7:0] m_rd, m_bo;
  logic [3:0] m_le;

  int n_chk = 0;
  int n_err = 0;
  int viol  = 0;

  logic [3:0] log_le  [0:31];
  logic [3:0] log_len [0:31];
  logic [7:0] log_bo  [0:31];
  logic       log_boe [0:31];
  logic       log_oen [0:31];
  logic       log_wen [0:31];
  int         lat;
  logic [7:0] got_rdata;

  always #5 clk = ~clk;

  mux_bus_ctrl #(.ADDR_BYTES(2), .WAIT_W(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid & ~sel), .req_ready(rdy2),
    .req_we(req_we), .req_addr(req_addr[15:0]), .req_wdata(req_wdata),
    .wait_cycles(wait_cycles), .rsp_valid(rv2), .rsp_rdata(rd2), .bus_out(bo2),
    .bus_oe(boe2), .bus_in(bus_in), .le(le2), .oe_n(oen2), .we_n(wen2)
  );

  mux_bus_ctrl #(.ADDR_BYTES(3), .WAIT_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid & sel), .req_ready(rdy3),
    .req_we(req_we), .req_addr(req_addr[23:0]), .req_wdata(req_wdata),
    .wait_cycles(wait_cycles), .rsp_valid(rv3), .rsp_rdata(rd3), .bus_out(bo3),
    .bus_oe(boe3), .bus_in(bus_in), .le(le3), .oe_n(oen3), .we_n(wen3)
  );

  always_comb begin
    m_ready = sel ? rdy3 : rdy2;
    m_rv    = sel ? rv3  : rv2;
    m_rd    = sel ? rd3  : rd2;
    m_bo    = sel ? bo3  : bo2;
    m_boe   = sel ? boe3 : boe2;
    m_oen   = sel ? oen3 : oen2;
    m_wen   = sel ? wen3 : wen2;
    m_le    = sel ? {1'b0, le3} : {2'b00, le2};
  end

  // Enables must never overlap each other or an address strobe.
  always @(posedge clk) begin
    #1;
    if (!oen2 && !wen2) viol++;
    if ((!oen2 || !wen2) && le2 != 2'b00) viol++;
    if (!oen3 && !wen3) viol++;
    if ((!oen3 || !wen3) && le3 != 3'b000) viol++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic start_req(input logic s, input logic we, input logic [31:0] a,
                           input logic [7:0] wd, input logic [2:0] w);
    int n;
    sel = s;
    n = 0;
    @(negedge clk);
    while (!m_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", 32'(n < 20), 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; wait_cycles = w;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_cycles = 3'd7;
  endtask

  task automatic xfer(input logic s, input logic we, input logic [31:0] a,
                      input logic [7:0] wd, input logic [2:0] w);
    start_req(s, we, a, wd, w);
    for (int k = 0; k < 32; k++) begin
      log_le[k] = '0; log_len[k] = '0; log_bo[k] = '0;
      log_boe[k] = 1'b0; log_oen[k] = 1'b1; log_wen[k] = 1'b1;
    end
    lat = 0;
    for (int n = 1; n < 24; n++) begin
      if (n > 1) begin
        @(posedge clk);
        #1;
      end
      log_le[n] = m_le; log_bo[n] = m_bo; log_boe[n] = m_boe;
      log_oen[n] = m_oen; log_wen[n] = m_wen;
      if (m_rv) begin
        lat = n;
        got_rdata = m_rd;
        break;
      end
      @(negedge clk);
      #1;
      log_len[n] = m_le;
    end
    @(posedge clk);
    #1;
    check("rsp_single_pulse", 32'(m_rv), 32'd0);
    check("ready_after_recover", 32'(m_ready), 32'd1);
  endtask

  function automatic int count_low_oe();
    int c = 0;
    for (int k = 1; k < 32; k++) if (!log_oen[k]) c++;
    return c;
  endfunction

  function automatic int count_low_we();
    int c = 0;
    for (int k = 1; k < 32; k++) if (!log_wen[k]) c++;
    return c;
  endfunction

  initial begin
    int n;
    logic seen;

    #12;
    check("rst_ready", 32'(rdy2), 32'd0);
    check("rst_rsp_valid", 32'(rv2), 32'd0);
    check("rst_rdata", 32'(rd2), 32'h00);
    check("rst_bus_out", 32'(bo2), 32'h00);
    check("rst_bus_oe", 32'(boe2), 32'd0);
    check("rst_le", 32'(le2), 32'd0);
    check("rst_oe_n", 32'(oen2), 32'd1);
    check("rst_we_n", 32'(wen2), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", 32'(rdy2), 32'd0);
    @(posedge clk);
    #1;
    check("ready_after_release", 32'(rdy2), 32'd1);

    // Read 0xC703, no wait states.
    bus_in = 8'h69;
    xfer(1'b0, 1'b0, 32'h0000C703, 8'h00, 3'd0);
    check("rd_le_c1", 32'(log_le[1]), 32'h2);
    check("rd_bo_c1", 32'(log_bo[1]), 32'hC7);
    check("rd_boe_c1", 32'(log_boe[1]), 32'd1);
    check("rd_le_fall_c1", 32'(log_len[1]), 32'h0);
    check("rd_le_c2", 32'(log_le[2]), 32'h1);
    check("rd_bo_c2", 32'(log_bo[2]), 32'h03);
    check("rd_oe_n_c3", 32'(log_oen[3]), 32'd0);
    check("rd_boe_c3", 32'(log_boe[3]), 32'd0);
    check("rd_oe_cycles", 32'(count_low_oe()), 32'd1);
    check("rd_latency", 32'(lat), 32'd4);
    check("rd_rdata", 32'(got_rdata), 32'h69);

    // Write 0x72 to 0x2003 with 2 wait states; wait_cycles is changed after accept.
    xfer(1'b0, 1'b1, 32'h00002003, 8'h72, 3'd2);
    check("wr_le_c1", 32'(log_le[1]), 32'h2);
    check("wr_bo_c1", 32'(log_bo[1]), 32'h20);
    check("wr_we_cycles", 32'(count_low_we()), 32'd3);
    check("wr_oe_cycles", 32'(count_low_oe()), 32'd0);
    for (int k = 3; k <= 5; k++) begin
      check("wr_we_n", 32'(log_wen[k]), 32'd0);
      check("wr_bus_out", 32'(log_bo[k]), 32'h72);
      check("wr_bus_oe", 32'(log_boe[k]), 32'd1);
    end
    check("wr_latency", 32'(lat), 32'd6);

    // Upper-byte cache sequence.
    bus_in = 8'h5A;
    xfer(1'b0, 1'b0, 32'h0000606A, 8'h00, 3'd0);
    check("c1_latency", 32'(lat), 32'd4);
    check("c1_le_c1", 32'(log_le[1]), 32'h2);
    check("c1_rdata", 32'(got_rdata), 32'h5A);
    xfer(1'b0, 1'b0, 32'h0000606B, 8'h00, 3'd0);
`ifdef MBC_HICACHE_EN
    check("c2_latency", 32'(lat), 32'd3);
    check("c2_le_c1", 32'(log_le[1]), 32'h1);
    check("c2_bo_c1", 32'(log_bo[1]), 32'h6B);
`else
    check("c2_latency", 32'(lat), 32'd4);
    check("c2_le_c1", 32'(log_le[1]), 32'h2);
    check("c2_bo_c1", 32'(log_bo[1]), 32'h60);
`endif
    xfer(1'b0, 1'b0, 32'h0000616B, 8'h00, 3'd0);
    check("c3_latency", 32'(lat), 32'd4);
    check("c3_le_c1", 32'(log_le[1]), 32'h2);
    check("c3_bo_c1", 32'(log_bo[1]), 32'h61);

    // Three address bytes.
    bus_in = 8'hA5;
    xfer(1'b1, 1'b0, 32'h0012345F, 8'h00, 3'd0);
    check("ab3_le_c1", 32'(log_le[1]), 32'h4);
    check("ab3_bo_c1", 32'(log_bo[1]), 32'h12);
    check("ab3_le_c2", 32'(log_le[2]), 32'h2);
    check("ab3_bo_c2", 32'(log_bo[2]), 32'h34);
    check("ab3_le_c3", 32'(log_le[3]), 32'h1);
    check("ab3_bo_c3", 32'(log_bo[3]), 32'h5F);
    check("ab3_latency", 32'(lat), 32'd5);
    check("ab3_rdata", 32'(got_rdata), 32'hA5);

    // Reset during the access phase of a read at the cached address.
    bus_in = 8'h3C;
    start_req(1'b0, 1'b0, 32'h0000616B, 8'h00, 3'd3);
    n = 0;
    while (m_oen && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("abort_in_access", 32'(m_oen), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_oe_n", 32'(m_oen), 32'd1);
    check("abort_bus_oe", 32'(m_boe), 32'd0);
    check("abort_ready", 32'(m_ready), 32'd0);
    seen = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (m_rv) seen = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (m_rv) seen = 1'b1;
    end
    check("abort_no_rsp", 32'(seen), 32'd0);
    xfer(1'b0, 1'b0, 32'h0000616B, 8'h00, 3'd0);
    check("post_abort_le_c1", 32'(log_le[1]), 32'h2);
    check("post_abort_bo_c1", 32'(log_bo[1]), 32'h61);
    check("post_abort_latency", 32'(lat), 32'd4);
    check("post_abort_rdata", 32'(got_rdata), 32'h3C);

    check("enable_exclusion", 32'(viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
